// File: rtl/textcon_writer.sv
// textcon_writer: byte-stream text writer for the 2KB character VRAM.
// Keeps a cursor, handles CR/LF/BS/FF and drives the VRAM write port.
// VRAM address layout is {row[4:0], col[5:0]}.
// Optional macro TEXTCON_CLEAR_ON_RESET_EN: when defined, the block clears
// the whole VRAM automatically after reset is released.
module textcon_writer #(
  parameter int unsigned COLS  = 40,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        vram_we,
  output logic [10:0] vram_waddr,
  output logic [7:0]  vram_wdata,
  output logic [4:0]  cursor_row,
  output logic [5:0]  cursor_col,
  output logic        busy
);

  localparam logic [5:0] ColLast = 6'(COLS - 1);
  localparam logic [4:0] RowLast = 5'(ROWS - 1);

  // StDrain holds off in_ready for one cycle after the last clear write.
  typedef enum logic [1:0] {StIdle, StClear, StDrain} state_e;

  state_e      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic [10:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [10:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic [4:0]  row_next;

  // Row advance wraps at ROWS-1; there is no scrolling.
  always_comb begin
    row_next = (row_q == RowLast) ? 5'd0 : row_q + 5'd1;
  end

  // Next-state: byte decode in idle, sequential fill while clearing.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          case (in_data)
            8'h0A: begin
              col_d = 6'd0;
              row_d = row_next;
            end
            8'h0D: col_d = 6'd0;
            8'h08: begin
              if (col_q != 6'd0) col_d = col_q - 6'd1;
            end
            8'h0C: begin
              state_d = StClear;
              cnt_d   = 11'd0;
              busy_d  = 1'b1;
            end
            default: begin
              // Remaining control codes are swallowed silently.
              if (in_data >= 8'h20) begin
                we_d    = 1'b1;
                waddr_d = {row_q, col_q};
                wdata_d = in_data;
                if (col_q == ColLast) begin
                  col_d = 6'd0;
                  row_d = row_next;
                end else begin
                  col_d = col_q + 6'd1;
                end
              end
            end
          endcase
        end
      end
      StClear: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = BLANK;
        cnt_d   = cnt_q + 11'd1;
        if (cnt_q == 11'h7FF) begin
          state_d = StDrain;
          busy_d  = 1'b0;
          row_d   = 5'd0;
          col_d   = 6'd0;
        end
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs, asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef TEXTCON_CLEAR_ON_RESET_EN
      state_q <= StClear;
      busy_q  <= 1'b1;
`else
      state_q <= StIdle;
      busy_q  <= 1'b0;
`endif
      row_q   <= 5'd0;
      col_q   <= 6'd0;
      cnt_q   <= 11'd0;
      we_q    <= 1'b0;
      waddr_q <= 11'd0;
      wdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign vram_we    = we_q;
  assign vram_waddr = waddr_q;
  assign vram_wdata = wdata_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_textcon_writer.sv
// Directed bench for textcon_writer: vector table plus multi-cycle sequences.
module tb_textcon_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        vram_we;
  logic [10:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic [4:0]  cursor_row;
  logic [5:0]  cursor_col;
  logic        busy;

  int checks = 0;
  int errors = 0;

  textcon_writer dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vram_we    (vram_we),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    logic        we;
    logic [10:0] waddr;
    logic [7:0]  wdata;
    logic [4:0]  row;
    logic [5:0]  col;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_cursor(input string name, input int r, input int c);
    chk({name, ".row"}, 32'(cursor_row), 32'(r));
    chk({name, ".col"}, 32'(cursor_col), 32'(c));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
`ifdef TEXTCON_CLEAR_ON_RESET_EN
    for (int i = 0; i < 2100 && !in_ready; i++) @(negedge clk);
    chk("reset_clear_done", 32'(in_ready), 32'd1);
`else
    @(negedge clk);
`endif
  endtask

  // Present one byte for one edge, outputs are visible on return.
  task automatic put(input logic [7:0] b);
    in_data = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{8'h41, 1'b1, 11'h000, 8'h41, 5'd0, 6'd1};
    vecs[1]  = '{8'h42, 1'b1, 11'h001, 8'h42, 5'd0, 6'd2};
    vecs[2]  = '{8'h01, 1'b0, 11'h000, 8'h00, 5'd0, 6'd2};
    vecs[3]  = '{8'h1B, 1'b0, 11'h000, 8'h00, 5'd0, 6'd2};
    vecs[4]  = '{8'h08, 1'b0, 11'h000, 8'h00, 5'd0, 6'd1};
    vecs[5]  = '{8'h08, 1'b0, 11'h000, 8'h00, 5'd0, 6'd0};
    vecs[6]  = '{8'h08, 1'b0, 11'h000, 8'h00, 5'd0, 6'd0};
    vecs[7]  = '{8'h0A, 1'b0, 11'h000, 8'h00, 5'd1, 6'd0};
    vecs[8]  = '{8'h80, 1'b1, 11'h040, 8'h80, 5'd1, 6'd1};
    vecs[9]  = '{8'h7F, 1'b1, 11'h041, 8'h7F, 5'd1, 6'd2};
    vecs[10] = '{8'h0D, 1'b0, 11'h000, 8'h00, 5'd1, 6'd0};

    // Reset values while reset is held.
    #1;
    chk("rst.we", 32'(vram_we), 32'd0);
    chk("rst.waddr", 32'(vram_waddr), 32'd0);
    chk("rst.wdata", 32'(vram_wdata), 32'd0);
    chk_cursor("rst", 0, 0);
`ifndef TEXTCON_CLEAR_ON_RESET_EN
    chk("rst.busy", 32'(busy), 32'd0);
`endif
    do_reset();
    chk("idle.in_ready", 32'(in_ready), 32'd1);

    // Back-to-back vector table, one byte per cycle.
    for (int i = 0; i < 11; i++) begin
      in_data = vecs[i].din;
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d.we", i), 32'(vram_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("vec%0d.waddr", i), 32'(vram_waddr), 32'(vecs[i].waddr));
        chk($sformatf("vec%0d.wdata", i), 32'(vram_wdata), 32'(vecs[i].wdata));
      end
      chk_cursor($sformatf("vec%0d", i), int'(vecs[i].row), int'(vecs[i].col));
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;

    // Column wrap at COLS-1 on row 0.
    do_reset();
    repeat (39) put(8'h2E);
    chk_cursor("colwrap.pre", 0, 39);
    put(8'h58);
    chk("colwrap.we", 32'(vram_we), 32'd1);
    chk("colwrap.waddr", 32'(vram_waddr), 32'h027);
    chk("colwrap.wdata", 32'(vram_wdata), 32'h58);
    chk_cursor("colwrap", 1, 0);

    // Full wrap from the last visible cell back to origin.
    do_reset();
    repeat (29) put(8'h0A);
    repeat (39) put(8'h2E);
    chk_cursor("lastcell.pre", 29, 39);
    put(8'h58);
    chk("lastcell.we", 32'(vram_we), 32'd1);
    chk("lastcell.waddr", 32'(vram_waddr), 32'h767);
    chk_cursor("lastcell", 0, 0);

    // CR, LF, BS-at-column-0 from (3,5).
    do_reset();
    repeat (3) put(8'h0A);
    repeat (5) put(8'h2E);
    chk_cursor("ctl.pre", 3, 5);
    put(8'h0D);
    chk("cr.we", 32'(vram_we), 32'd0);
    chk_cursor("cr", 3, 0);
    put(8'h0A);
    chk("lf.we", 32'(vram_we), 32'd0);
    chk_cursor("lf", 4, 0);
    put(8'h08);
    chk("bs0.we", 32'(vram_we), 32'd0);
    chk_cursor("bs0", 4, 0);

    // FF clear with 'A' held valid throughout.
    do_reset();
    put(8'h5A);
    in_data = 8'h0C;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'h41;
    chk("ff.busy", 32'(busy), 32'd1);
    chk("ff.in_ready", 32'(in_ready), 32'd0);
    chk("ff.we", 32'(vram_we), 32'd0);
    begin
      int k = 0;
      int nwr = 0;
      int bad = 0;
      int busy_n = 0;
      int ready_at = -1;
      bit got_a = 1'b0;
      while (k < 2200 && !got_a) begin
        if (busy) busy_n++;
        if (ready_at >= 0 && k == ready_at + 1) in_valid = 1'b0;
        if (in_ready && ready_at < 0) begin
          ready_at = k;
          chk_cursor("clr.end", 0, 0);
        end
        if (vram_we) begin
          if (ready_at < 0) begin
            if (vram_waddr != 11'(nwr) || vram_wdata != 8'h20) bad++;
            nwr++;
          end else begin
            got_a = 1'b1;
            chk("a.waddr", 32'(vram_waddr), 32'h000);
            chk("a.wdata", 32'(vram_wdata), 32'h41);
            chk("a.latency", 32'(k), 32'(ready_at + 1));
            chk_cursor("a", 0, 1);
          end
        end
        @(negedge clk);
        k++;
      end
      in_valid = 1'b0;
      chk("clr.writes", 32'(nwr), 32'd2048);
      chk("clr.bad_writes", 32'(bad), 32'd0);
      chk("clr.busy_cycles", 32'(busy_n), 32'd2048);
      chk("clr.ready_at", 32'(ready_at), 32'd2049);
      chk("clr.got_a", 32'(got_a), 32'd1);
    end

    // Reset in the middle of a clear.
    do_reset();
    put(8'h0C);
    repeat (100) @(negedge clk);
    chk("mid.busy", 32'(busy), 32'd1);
    chk("mid.waddr", 32'(vram_waddr), 32'd99);
    reset = 1'b1;
    #1;
    chk("mid.rst.we", 32'(vram_we), 32'd0);
    chk_cursor("mid.rst", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`ifdef TEXTCON_CLEAR_ON_RESET_EN
    chk("mid.restart.we", 32'(vram_we), 32'd1);
    chk("mid.restart.waddr", 32'(vram_waddr), 32'd0);
`else
    chk("mid.post.we", 32'(vram_we), 32'd0);
    chk("mid.post.busy", 32'(busy), 32'd0);
    chk("mid.post.in_ready", 32'(in_ready), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/textcon_writer.md
Name: textcon_writer

Overview:
- Write-side counterpart of the character display readers: turns a byte stream of characters into writes on the 2KB text VRAM that the pixel/char readers fetch from.
- Keeps a cursor and interprets a small set of control codes (CR, LF, BS, FF).
- Drives the write port of the dual-port sync SRAM; the display path owns the read port.
- VRAM address layout is fixed as {row[4:0], col[5:0]}: 32 row slots of 64 column slots.

Parameters:
- COLS, 40, visible columns per row (1..64); the cursor wraps at COLS-1.
- ROWS, 30, visible rows (1..32); the cursor wraps at ROWS-1.
- BLANK, 8'h20, fill byte written during clear.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  character or control code.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- vram_we  output  1  registered write strobe to VRAM.
- vram_waddr  output  11  registered write address {row, col}.
- vram_wdata  output  8  registered write data.
- cursor_row  output  5  current cursor row.
- cursor_col  output  6  current cursor column.
- busy  output  1  high while a clear is in progress.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, cursor_row=0, cursor_col=0.
  - vram_we=0, vram_waddr=0, vram_wdata=0.
  - busy=0, in_ready=1 once reset is released.
- Accept rule: a byte is accepted on a clock edge where in_valid && in_ready. in_ready = (state==IDLE). The block can accept one byte every cycle.
- All outputs are registered. A write from an accepted byte appears on vram_we/waddr/wdata for exactly the one cycle after acceptance.
- Printable byte (any value not listed below, including >=0x7F):
  - Write: waddr={cursor_row, cursor_col}, wdata=in_data.
  - Cursor advance: if col==COLS-1 then col=0 and the row advances, otherwise col+1.
- 0x0A LF: col=0, row advances; no write.
- 0x0D CR: col=0; no write.
- 0x08 BS: if col>0 then col-1; at col 0 the cursor is unchanged. No write and no erase.
- 0x0C FF: enter the CLEAR state; no write in the accept cycle.
- Other bytes <0x20: consumed and ignored; no write, cursor unchanged.
- Row advance: row==ROWS-1 wraps to 0. There is no scrolling.
- CLEAR state:
  - busy=1, in_ready=0.
  - An internal 11-bit counter runs 0..2047, one write per cycle: vram_we=1, waddr=counter, wdata=BLANK.
  - All 2048 locations are written, including off-screen slots.
  - After the write to 2047 is issued: cursor=(0,0), state=IDLE, busy=0.
  - in_ready rises in the cycle after the last write is on the outputs.
  - Total time from FF acceptance to in_ready=1 is 2049 cycles.
- Cursor outputs update on the same edge as the write outputs. They show the position for the next character.
- reset asserted mid-clear or mid-write:
  - Immediate return to reset values and the clear is abandoned.
  - A VRAM left partially cleared is acceptable.
- in_valid while busy: the byte is not consumed. The source holds it until in_ready.
- Data width and wrap arithmetic:
  - Column and row compares are against COLS-1 and ROWS-1, not power-of-two wrap.
  - Slots with col>=COLS or row>=ROWS are never written by character output.

Optional Feature:
- TEXTCON_CLEAR_ON_RESET_EN
- Defined:
  - On reset release the block enters CLEAR automatically (busy=1, in_ready=0).
  - It fills VRAM with BLANK over 2048 cycles, then goes to IDLE with cursor (0,0).
- Undefined:
  - After reset the block sits in IDLE with in_ready=1 and VRAM contents untouched.

Test Plan:
- Reset, then send 'A','B' (0x41, 0x42) back-to-back -> writes (addr 0x000, 0x41), (addr 0x001, 0x42) on consecutive cycles; cursor=(0,2).
- Cursor at (0,39), send 0x58 -> write at addr 0x027; cursor=(1,0). Cursor at (29,39), send 0x58 -> write at addr 0x767; cursor=(0,0).
- Cursor at (3,5), send 0x0D, 0x0A, 0x08 -> no vram_we; cursor (3,0), then (4,0), then (4,0).
- Send 0x0C then hold 0x41 valid -> busy=1 for 2048 cycles, writes 0x20 to addresses 0..2047 in order; 'A' is accepted only after busy falls and is written at addr 0x000.
- Assert reset at clear count ~100 -> vram_we=0 and cursor (0,0) immediately; with TEXTCON_CLEAR_ON_RESET_EN the clear restarts at addr 0 after release.
- Send 0x01 and 0x1B -> consumed (in_ready stays 1), no write, cursor unchanged.
